// File: rtl/mips_pkg.sv
// Shared types and constants for the mips instruction-fetch front end.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    localparam int          INSTR_W   = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

endpackage

// File: rtl/mips_fetch_stage_if.sv
// Instruction-memory channel: valid/ready request plus response-valid read data.
interface mips_fetch_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    modport master (output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
    modport slave  (input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/mips_ifid_reg.sv
// IF/ID pipeline register: holds one fetched word until decode consumes it.
module mips_ifid_reg
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              flush,
    input  logic              consume,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4
);

    // Flush only clears valid; stale contents are harmless once valid drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid    <= 1'b0;
            instr    <= DATA_W'(INSTR_NOP);
            pc       <= '0;
            pc_plus4 <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid    <= 1'b1;
            instr    <= in_instr;
            pc       <= in_pc;
            pc_plus4 <= in_pc + ADDR_W'(4);
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mips_fetch_stage.sv
// Fetch front end: owns the PC, keeps at most one imem read in flight, and
// discards responses made stale by an EX redirect.
module mips_fetch_stage
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    mips_fetch_stage_if.master        imem,
    input  logic                      redirect_valid,
    input  logic [ADDR_W-1:0]         redirect_pc,
    output logic                      id_valid,
    input  logic                      id_ready,
    output logic [DATA_W-1:0]         id_instr,
    output logic [ADDR_W-1:0]         id_pc,
    output logic [ADDR_W-1:0]         id_pc_plus4
);

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] pc;
    logic              req_valid;
    logic              handshake;
    logic              flush;
    logic              load;

    // Only request when the IF/ID slot is guaranteed free by the next edge.
    assign req_valid     = (state == REQ) && (!id_valid || id_ready);
    assign handshake     = req_valid && imem.req_ready;
    assign flush         = redirect_valid && (state != IDLE);
    assign load          = (state == WAIT) && imem.rsp_valid && !redirect_valid;
    assign imem.req_valid = req_valid;
    assign imem.req_addr  = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (handshake) begin
                    state_next = redirect_valid ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem.rsp_valid) begin
                    state_next = REQ;
                end else if (redirect_valid) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (imem.rsp_valid) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (flush) begin
            pc <= redirect_pc & ~ADDR_W'(3);
        end else if (load) begin
            pc <= pc + ADDR_W'(4);
        end
    end

    mips_ifid_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ifid (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .flush    (flush),
        .consume  (id_ready),
        .in_instr (imem.rsp_data),
        .in_pc    (pc),
        .valid    (id_valid),
        .instr    (id_instr),
        .pc       (id_pc),
        .pc_plus4 (id_pc_plus4)
    );

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed bench for mips_fetch_stage: cycle vector table plus redirect/reset/wrap sequences.
module tb_mips_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    int checks   = 0;
    int failures = 0;
    int outstanding = 0;

    mips_fetch_stage_if #(.ADDR_W(32), .DATA_W(32)) imem ();

    mips_fetch_stage #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (imem),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        rspv;
        logic        idr;
        logic [31:0] rspd;
        logic        reqv;
        logic [31:0] addr;
        logic        idv;
        logic [31:0] idpc;
        logic [31:0] instr;
    } vec_t;

    function automatic logic [31:0] dw(input logic [31:0] a);
        return 32'h2400_0000 | a;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic rdy, input logic rspv, input logic [31:0] rspd,
                         input logic idr, input logic redv, input logic [31:0] redpc);
        imem.req_ready = rdy;
        imem.rsp_valid = rspv;
        imem.rsp_data  = rspd;
        id_ready       = idr;
        redirect_valid = redv;
        redirect_pc    = redpc;
    endtask

    // Protocol monitor: single outstanding request and word-aligned addresses.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding = 0;
        end else begin
            if (imem.rsp_valid && outstanding > 0) outstanding--;
            if (imem.req_valid && imem.req_ready) begin
                chk("single_outstanding", 32'(outstanding), 32'd0);
                chk("addr_aligned", {30'd0, imem.req_addr[1:0]}, 32'd0);
                outstanding++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    vec_t vt[18];

    initial begin
        vt[0]  = '{1'b1, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0,  1'b0, 32'h0, 32'h0};
        vt[1]  = '{1'b1, 1'b0, 1'b1, 32'h0,        1'b1, 32'h0,  1'b0, 32'h0, 32'h0};
        vt[2]  = '{1'b1, 1'b1, 1'b1, dw(32'h0),    1'b0, 32'h0,  1'b0, 32'h0, 32'h0};
        vt[3]  = '{1'b1, 1'b0, 1'b1, 32'h0,        1'b1, 32'h4,  1'b1, 32'h0, dw(32'h0)};
        vt[4]  = '{1'b1, 1'b1, 1'b1, dw(32'h4),    1'b0, 32'h4,  1'b0, 32'h0, dw(32'h0)};
        vt[5]  = '{1'b0, 1'b0, 1'b1, 32'h0,        1'b1, 32'h8,  1'b1, 32'h4, dw(32'h4)};
        vt[6]  = '{1'b0, 1'b0, 1'b1, 32'h0,        1'b1, 32'h8,  1'b0, 32'h4, dw(32'h4)};
        vt[7]  = '{1'b0, 1'b0, 1'b1, 32'h0,        1'b1, 32'h8,  1'b0, 32'h4, dw(32'h4)};
        vt[8]  = '{1'b1, 1'b0, 1'b1, 32'h0,        1'b1, 32'h8,  1'b0, 32'h4, dw(32'h4)};
        vt[9]  = '{1'b1, 1'b1, 1'b1, dw(32'h8),    1'b0, 32'h8,  1'b0, 32'h4, dw(32'h4)};
        vt[10] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'hC,  1'b1, 32'h8, dw(32'h8)};
        vt[11] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'hC,  1'b1, 32'h8, dw(32'h8)};
        vt[12] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'hC,  1'b1, 32'h8, dw(32'h8)};
        vt[13] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'hC,  1'b1, 32'h8, dw(32'h8)};
        vt[14] = '{1'b1, 1'b0, 1'b1, 32'h0,        1'b1, 32'hC,  1'b1, 32'h8, dw(32'h8)};
        vt[15] = '{1'b1, 1'b0, 1'b1, 32'h0,        1'b0, 32'hC,  1'b0, 32'h8, dw(32'h8)};
        vt[16] = '{1'b1, 1'b1, 1'b1, dw(32'hC),    1'b0, 32'hC,  1'b0, 32'h8, dw(32'h8)};
        vt[17] = '{1'b1, 1'b0, 1'b1, 32'h0,        1'b1, 32'h10, 1'b1, 32'hC, dw(32'hC)};

        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_valid", {31'd0, imem.req_valid}, 32'd0);
        chk("rst_req_addr", imem.req_addr, 32'h0);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_pc_plus4", id_pc_plus4, 32'h0);
        rst = 1'b1;

        // Streaming, imem back-pressure and decode stall.
        for (int i = 0; i < 18; i++) begin
            drive(vt[i].rdy, vt[i].rspv, vt[i].rspd, vt[i].idr, 1'b0, 32'h0);
            #1;
            chk($sformatf("v%0d_req_valid", i), {31'd0, imem.req_valid}, {31'd0, vt[i].reqv});
            chk($sformatf("v%0d_req_addr", i), imem.req_addr, vt[i].addr);
            chk($sformatf("v%0d_id_valid", i), {31'd0, id_valid}, {31'd0, vt[i].idv});
            chk($sformatf("v%0d_id_pc", i), id_pc, vt[i].idpc);
            chk($sformatf("v%0d_id_instr", i), id_instr, vt[i].instr);
            if (vt[i].idv) chk($sformatf("v%0d_id_pc_plus4", i), id_pc_plus4, vt[i].idpc + 32'd4);
            @(negedge clk);
        end

        // Redirect while waiting on a slow response: the response must be dropped.
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0103);
        #1 chk("rw_req_valid", {31'd0, imem.req_valid}, 32'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        #1 chk("rw_drop_addr", imem.req_addr, 32'h100);
        chk("rw_drop_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rw_drop_req_valid", {31'd0, imem.req_valid}, 32'd0);
        @(negedge clk);
        drive(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        #1 chk("rw_req_valid_after", {31'd0, imem.req_valid}, 32'd1);
        chk("rw_req_addr_after", imem.req_addr, 32'h100);
        chk("rw_stale_not_loaded", id_instr, dw(32'hC));
        @(negedge clk);
        drive(1'b1, 1'b1, dw(32'h100), 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        #1 chk("rw_id_valid", {31'd0, id_valid}, 32'd1);
        chk("rw_id_pc", id_pc, 32'h100);
        chk("rw_id_pc_plus4", id_pc_plus4, 32'h104);
        chk("rw_id_instr", id_instr, dw(32'h100));
        chk("rw_next_addr", imem.req_addr, 32'h104);
        @(negedge clk);

        // Redirect coinciding with the response.
        drive(1'b1, 1'b1, 32'h0BAD_0BAD, 1'b1, 1'b1, 32'h0000_020A);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        #1 chk("rr_req_valid", {31'd0, imem.req_valid}, 32'd1);
        chk("rr_req_addr", imem.req_addr, 32'h208);
        chk("rr_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rr_id_instr", id_instr, dw(32'h100));
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);

        // Reset while waiting; the response arrives during reset.
        rst = 1'b0;
        drive(1'b1, 1'b1, 32'h00BA_DBAD, 1'b1, 1'b0, 32'h0);
        #1 chk("mr_req_valid", {31'd0, imem.req_valid}, 32'd0);
        chk("mr_req_addr", imem.req_addr, 32'h0);
        chk("mr_id_valid", {31'd0, id_valid}, 32'd0);
        chk("mr_id_instr", id_instr, 32'h0);
        chk("mr_id_pc", id_pc, 32'h0);
        chk("mr_id_pc_plus4", id_pc_plus4, 32'h0);
        @(negedge clk);
        #1 chk("mr_id_instr_hold", id_instr, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        rst = 1'b1;
        #1 chk("mr_idle_req_valid", {31'd0, imem.req_valid}, 32'd0);
        @(negedge clk);
        #1 chk("mr_first_req_valid", {31'd0, imem.req_valid}, 32'd1);
        chk("mr_first_req_addr", imem.req_addr, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b1, dw(32'h0), 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        #1 chk("mr_id_valid_post", {31'd0, id_valid}, 32'd1);
        chk("mr_id_instr_post", id_instr, dw(32'h0));
        chk("mr_id_pc_post", id_pc, 32'h0);
        @(negedge clk);

        // PC wrap from the top of the address space.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        #1 chk("wr_req_addr_before", imem.req_addr, 32'h4);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        #1 chk("wr_req_addr", imem.req_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h1357_9BDF, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1 chk("wr_id_pc", id_pc, 32'hFFFF_FFFC);
        chk("wr_id_pc_plus4", id_pc_plus4, 32'h0);
        chk("wr_id_instr", id_instr, 32'h1357_9BDF);
        chk("wr_next_addr", imem.req_addr, 32'h0);
        chk("wr_stall_req_valid", {31'd0, imem.req_valid}, 32'd0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
